// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator: keypad geometry, FSM state
// encoding and the digit-to-key position constants also used by the
// row-scanning side.
package keypad_emulator_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 3;
  localparam int DIGIT_W  = 4;
  localparam int LEN_W    = 4;

  // Lowest and highest digit that corresponds to a physical key.
  localparam logic [DIGIT_W-1:0] KEY_DIGIT_MIN = 4'd1;
  localparam logic [DIGIT_W-1:0] KEY_DIGIT_MAX = 4'd9;

  // One-hot row selects, row 1 (digits 1..3) on bit 0.
  localparam logic [NUM_ROWS-1:0] ROW_1 = 3'b001;
  localparam logic [NUM_ROWS-1:0] ROW_2 = 3'b010;
  localparam logic [NUM_ROWS-1:0] ROW_3 = 3'b100;

  // One-hot column selects, column 1 (digits 1, 4, 7) on bit 0.
  localparam logic [NUM_COLS-1:0] COL_1 = 3'b001;
  localparam logic [NUM_COLS-1:0] COL_2 = 3'b010;
  localparam logic [NUM_COLS-1:0] COL_3 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/keypad_emulator_if.sv
// Bundle of control, status and keypad-matrix signals between the
// sequencer owner (master) and the keypad emulator (slave).
//
// Handshake: start is a single-cycle request with no ready; it is taken
// only while the emulator is idle (busy=0 and done=0), and code/length are
// captured on that same edge. busy stays high until the run ends, done
// pulses for exactly one cycle with busy=0, and a new start is accepted
// from the cycle after done onward.
interface keypad_emulator_if
  import keypad_emulator_pkg::*;
#(
  parameter int MAX_DIGITS = 8
);
  logic                      start;
  logic [4*MAX_DIGITS-1:0]   code;
  logic [LEN_W-1:0]          length;
  logic                      keypad_r1;
  logic                      keypad_r2;
  logic                      keypad_r3;
  logic                      keypad_c1;
  logic                      keypad_c2;
  logic                      keypad_c3;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W-1:0]        key_active;
  logic                      err;
  state_t                    state_dbg;

  modport master (
    output start, code, length, keypad_r1, keypad_r2, keypad_r3,
    input  keypad_c1, keypad_c2, keypad_c3, busy, done, key_active, err,
           state_dbg
  );

  modport slave (
    input  start, code, length, keypad_r1, keypad_r2, keypad_r3,
    output keypad_c1, keypad_c2, keypad_c3, busy, done, key_active, err,
           state_dbg
  );
endinterface

// File: rtl/keypad_emulator_key_map.sv
// Maps a BCD digit to the one-hot row and column of its key on the 3x3
// keypad. Digits 0 and 10..15 have no key and report valid=0.
module keypad_emulator_key_map
  import keypad_emulator_pkg::*;
(
  input  logic [DIGIT_W-1:0]  digit,
  output logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic                valid
);

  // Digit d sits at row (d-1)/3, column (d-1)%3.
  always_comb begin
    row   = '0;
    col   = '0;
    valid = 1'b0;
    case (digit)
      4'd1: begin row = ROW_1; col = COL_1; valid = 1'b1; end
      4'd2: begin row = ROW_1; col = COL_2; valid = 1'b1; end
      4'd3: begin row = ROW_1; col = COL_3; valid = 1'b1; end
      4'd4: begin row = ROW_2; col = COL_1; valid = 1'b1; end
      4'd5: begin row = ROW_2; col = COL_2; valid = 1'b1; end
      4'd6: begin row = ROW_2; col = COL_3; valid = 1'b1; end
      4'd7: begin row = ROW_3; col = COL_1; valid = 1'b1; end
      4'd8: begin row = ROW_3; col = COL_2; valid = 1'b1; end
      4'd9: begin row = ROW_3; col = COL_3; valid = 1'b1; end
      default: begin
        row   = '0;
        col   = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: presses a latched digit sequence (most significant digit
// first) on the column lines, answering the scanner's row drives
// combinationally while a key is held. Each key is held HOLD_CYCLES and
// followed by GAP_CYCLES of release.
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int HOLD_CYCLES = 120000,
  parameter int GAP_CYCLES  = 120000,
  parameter int MAX_DIGITS  = 8
)(
  input  logic hwclk,
  input  logic reset,
  keypad_emulator_if.slave kp
);

  localparam int CODE_W    = 4 * MAX_DIGITS;
  localparam int IDX_W     = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int DWELL_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_DIGITS);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 err_q, err_d;
  logic [LEN_W-1:0]     len_c;

  logic [DIGIT_W-1:0]   digit;
  logic [NUM_ROWS-1:0]  key_row;
  logic [NUM_COLS-1:0]  key_col;
  logic                 key_valid;
  logic                 press_q;
  logic                 row_hit;

  // Digit under the index pointer; only meaningful in PRESS.
  assign digit = code_q[4*idx_q +: 4];

  keypad_emulator_key_map u_key_map (
    .digit (digit),
    .row   (key_row),
    .col   (key_col),
    .valid (key_valid)
  );

  // State, dwell counter, index, latched code and sticky error registers.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: launch, hold/gap dwell timing and digit stepping.
  // The dwell counter is cleared on every state change so each PRESS and
  // GAP starts counting from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    code_d  = code_q;
    err_d   = err_q;
    len_c   = kp.length;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (kp.start) begin
          code_d = kp.code;
          if (kp.length > LEN_MAX) begin
            len_c = LEN_MAX;
            err_d = 1'b1;
          end else begin
            len_c = kp.length;
            err_d = 1'b0;
          end
          idx_d = IDX_W'(len_c - 4'd1);
          if (len_c == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_PRESS;
          end
        end
      end
      ST_PRESS: begin
        if (!key_valid) begin
          err_d = 1'b1;
        end
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_PRESS;
          end
        end
      end
      ST_FIN: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A key is physically closed only in PRESS with a digit that has a key.
  assign press_q = (state_q == ST_PRESS) && key_valid;

  // The pressed key connects its row to its column: zero-latency loopback.
  assign row_hit = |(key_row & {kp.keypad_r3, kp.keypad_r2, kp.keypad_r1});

  assign kp.keypad_c1  = press_q & key_col[0] & row_hit;
  assign kp.keypad_c2  = press_q & key_col[1] & row_hit;
  assign kp.keypad_c3  = press_q & key_col[2] & row_hit;

  assign kp.busy       = (state_q == ST_PRESS) || (state_q == ST_GAP);
  assign kp.done       = (state_q == ST_FIN);
  assign kp.key_active = press_q ? digit : '0;
  assign kp.err        = err_q;
  assign kp.state_dbg  = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator with short hold/gap times. Expected behaviour
// comes from a per-cycle trace built from the digit list and slot times.
module tb_keypad_emulator;
  import keypad_emulator_pkg::*;

  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int MAXD = 8;
  localparam int SLOT = HOLD + GAP;

  // ---------------- clock / reset ----------------
  logic hwclk = 1'b0;
  logic reset;
  always #5 hwclk = ~hwclk;

  keypad_emulator_if #(.MAX_DIGITS(MAXD)) kp ();

  keypad_emulator #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .MAX_DIGITS  (MAXD)
  ) dut (
    .hwclk (hwclk),
    .reset (reset),
    .kp    (kp)
  );

  logic [2:0] rows;
  logic [2:0] cols;
  assign kp.keypad_r1 = rows[0];
  assign kp.keypad_r2 = rows[1];
  assign kp.keypad_r3 = rows[2];
  assign cols = {kp.keypad_c3, kp.keypad_c2, kp.keypad_c1};

  int tests = 0;
  int fails = 0;

  // Scoreboard: one entry per cycle after start, {busy, done, key[3:0]}.
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: slots of HOLD pressed cycles plus GAP released cycles,
  // most significant digit first, then one done cycle.
  task automatic build_trace(input logic [31:0] code, input int len, output logic exp_err);
    int n;
    logic [3:0] d;
    logic ok;
    n = (len > MAXD) ? MAXD : len;
    exp_err = (len > MAXD);
    exp_q.delete();
    for (int s = n - 1; s >= 0; s--) begin
      d  = code[4*s +: 4];
      ok = (d >= 4'd1) && (d <= 4'd9);
      if (!ok) exp_err = 1'b1;
      for (int h = 0; h < HOLD; h++) exp_q.push_back({1'b1, 1'b0, ok ? d : 4'd0});
      for (int g = 0; g < GAP; g++)  exp_q.push_back({1'b1, 1'b0, 4'd0});
    end
    exp_q.push_back({1'b0, 1'b1, 4'd0});
  endtask

  // Expected columns: key d closes row (d-1)/3 onto column (d-1)%3.
  function automatic logic [2:0] exp_cols(input logic [3:0] key, input logic [2:0] r);
    int p;
    if (key == 4'd0) return 3'b000;
    p = int'(key) - 1;
    return r[p / 3] ? 3'(1 << (p % 3)) : 3'b000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_rows(input int mode, input int k);
    if (mode == 0) rows = 3'(1 << (k % 3));
    else if (mode == 1) rows = 3'($urandom_range(0, 7));
    else rows = 3'b111;
  endtask

  // Runs a full sequence. Entered and left just after a rising edge.
  task automatic run_seq(input string name, input logic [31:0] code, input int len,
                         input int mode, input int restart_at);
    logic exp_err;
    logic [5:0] e;
    int k;
    build_trace(code, len, exp_err);
    kp.start  = 1'b1;
    kp.code   = code;
    kp.length = 4'(len);
    drive_rows(mode, 0);
    @(negedge hwclk);
    check({name, ":idle_busy"}, 32'(kp.busy), 32'd0);
    @(posedge hwclk); #1;
    kp.start  = 1'b0;
    kp.code   = $urandom;
    kp.length = 4'($urandom_range(0, 15));
    k = 1;
    while (exp_q.size() > 0 && k < 200) begin
      drive_rows(mode, k);
      if (k == restart_at) begin
        kp.start  = 1'b1;
        kp.code   = $urandom;
        kp.length = 4'($urandom_range(1, 15));
      end else begin
        kp.start = 1'b0;
      end
      @(negedge hwclk);
      e = exp_q.pop_front();
      check($sformatf("%s:busy@%0d", name, k), 32'(kp.busy), 32'(e[5]));
      check($sformatf("%s:done@%0d", name, k), 32'(kp.done), 32'(e[4]));
      check($sformatf("%s:key@%0d", name, k), 32'(kp.key_active), 32'(e[3:0]));
      check($sformatf("%s:cols@%0d", name, k), 32'(cols), 32'(exp_cols(e[3:0], rows)));
      if (k == 1) check({name, ":err_start"}, 32'(kp.err), 32'(len > MAXD));
      if (e[4]) check({name, ":err_done"}, 32'(kp.err), 32'(exp_err));
      @(posedge hwclk); #1;
      k++;
    end
    kp.start = 1'b0;
    @(negedge hwclk);
    check({name, ":after_state"}, 32'(kp.state_dbg), 32'(ST_IDLE));
    check({name, ":after_done"}, 32'(kp.done), 32'd0);
    @(posedge hwclk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic exp_err;
    logic [5:0] e;
    logic [31:0] rc;
    int done_seen;

    reset     = 1'b1;
    kp.start  = 1'b0;
    kp.code   = '0;
    kp.length = '0;
    rows      = 3'b111;
    repeat (3) @(posedge hwclk);
    @(negedge hwclk);
    check("rst:cols", 32'(cols), 32'd0);
    check("rst:busy", 32'(kp.busy), 32'd0);
    check("rst:done", 32'(kp.done), 32'd0);
    check("rst:key", 32'(kp.key_active), 32'd0);
    check("rst:err", 32'(kp.err), 32'd0);
    check("rst:state", 32'(kp.state_dbg), 32'(ST_IDLE));
    @(posedge hwclk); #1;
    reset = 1'b0;
    @(posedge hwclk); #1;

    // Digits 1,5,9 under a cycling row scan; done lands at cycle 22.
    run_seq("seq159", 32'h0000_0159, 3, 0, 0);

    // Empty sequence: done on the next cycle, nothing pressed.
    run_seq("len0", 32'h0000_1111, 0, 2, 0);

    // Invalid middle digit; err must survive into idle.
    run_seq("seq102", 32'h0000_0102, 3, 2, 0);
    repeat (3) begin
      @(negedge hwclk);
      check("err_sticky", 32'(kp.err), 32'd1);
      @(posedge hwclk); #1;
    end

    // Second start in the first PRESS is ignored; err clears on a clean start.
    run_seq("restart", 32'h0000_3478, 4, 1, 2);

    // Oversized length clamps to 8 digits; done at cycle 57.
    run_seq("len12", 32'h9876_5432, 12, 1, 0);

    // Reset in the middle of the second PRESS.
    build_trace(32'h0000_1234, 4, exp_err);
    kp.start  = 1'b1;
    kp.code   = 32'h0000_1234;
    kp.length = 4'd4;
    rows      = 3'b111;
    @(posedge hwclk); #1;
    kp.start = 1'b0;
    for (int k = 1; k <= SLOT + 2; k++) begin
      @(negedge hwclk);
      e = exp_q.pop_front();
      if (k == SLOT + 2) begin
        check("rstmid:key_before", 32'(kp.key_active), 32'(e[3:0]));
        check("rstmid:cols_before", 32'(cols), 32'(exp_cols(e[3:0], rows)));
      end
      @(posedge hwclk); #1;
    end
    reset = 1'b1;
    @(posedge hwclk); #1;
    reset = 1'b0;
    @(negedge hwclk);
    check("rstmid:cols", 32'(cols), 32'd0);
    check("rstmid:busy", 32'(kp.busy), 32'd0);
    check("rstmid:key", 32'(kp.key_active), 32'd0);
    done_seen = 0;
    repeat (4 * SLOT) begin
      @(posedge hwclk); #1;
      @(negedge hwclk);
      if (kp.done) done_seen++;
    end
    check("rstmid:no_done", 32'(done_seen), 32'd0);
    @(posedge hwclk); #1;

    // Randomized runs against the trace model.
    for (int r = 0; r < 6; r++) begin
      rc = '0;
      for (int j = 0; j < MAXD; j++) rc[4*j +: 4] = 4'($urandom_range(0, 11));
      run_seq($sformatf("rand%0d", r), rc, int'($urandom_range(0, 12)), 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
